// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: digit geometry, scan states, hex font.
// Font entries are active-low {g,f,e,d,c,b,a}.
// No handshake; constants only.
package seg_pkg;

   localparam int N_DIG = 8;
   localparam int NIB_W = 4;
   localparam int SEG_W = 7;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } scan_state_t;

   // Entry n is the glyph for nibble value n (0 rightmost).
   localparam logic [15:0][SEG_W-1:0] HEX_FONT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment glyph lookup.
// Latency: combinational.
// Backpressure: none.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [NIB_W-1:0] nib,
   output logic [SEG_W-1:0] seg_n
);

   assign seg_n = HEX_FONT[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit seven-segment scan controller with dead-time blanking; LEADING_ZERO_BLANK_EN darkens leading zeros.
// Latency: host word shown from the next frame boundary; seg_n trails sel by one cycle, hidden by the dead time.
// Backpressure: none; load always accepted, last load before the boundary wins, load_ack marks the commit.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIV_CYC  = 100000,
   parameter int DEAD_CYC = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_DIG*NIB_W-1:0] data_in,
   input  logic                   load,
   input  logic [N_DIG-1:0]       dig_en,
   output logic                   load_ack,
   output logic                   frame_done,
   output logic [N_DIG*NIB_W-1:0] disp_data,
   output logic [2:0]             sel,
   input  logic [NIB_W-1:0]       nibble_in,
   output logic [N_DIG-1:0]       an_n,
   output logic [SEG_W-1:0]       seg_n
);

   localparam int CNT_W = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC - 1);

   scan_state_t              state;
   scan_state_t              state_nxt;
   logic [CNT_W-1:0]         cnt;
   logic                     cnt_last;
   logic                     slot_end;
   logic                     frame_end;
   logic                     pend;
   logic [N_DIG*NIB_W-1:0]   pend_data;
   logic [SEG_W-1:0]         seg_dec;
   logic [N_DIG-1:0]         lz_dark;

   seg_hex_decode u_dec (
      .nib   (nibble_in),
      .seg_n (seg_dec)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Digit k is dark when it and every more-significant nibble are zero; digit 0 never blanks.
   always_comb begin
      lz_dark = '0;
      for (int k = 1; k < N_DIG; k++) begin
         lz_dark[k] = ((disp_data >> (NIB_W * k)) == '0);
      end
   end
`else
   assign lz_dark = '0;
`endif

   assign cnt_last  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (sel == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_BLANK;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      an_n      = '1;
      slot_end  = 1'b0;
      case (state)
         S_BLANK: begin
            if (cnt == CNT_DEAD) state_nxt = S_SHOW;
         end
         S_SHOW: begin
            if (dig_en[sel] && !lz_dark[sel]) an_n = ~(8'b1 << sel);
            if (cnt_last) begin
               state_nxt = S_BLANK;
               slot_end  = 1'b1;
            end
         end
         default: state_nxt = S_BLANK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         sel        <= '0;
         seg_n      <= '1;
         disp_data  <= '0;
         pend       <= 1'b0;
         pend_data  <= '0;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         cnt <= cnt_last ? '0 : cnt + 1'b1;
         // Decode only while anodes are off so the glyph is stable before the digit lights.
         if (state == S_BLANK) seg_n <= seg_dec;
         if (slot_end) sel <= sel + 3'd1;
         frame_done <= frame_end;
         load_ack   <= frame_end && (load || pend);
         if (frame_end) begin
            pend <= 1'b0;
            if (load) begin
               disp_data <= data_in;
            end else if (pend) begin
               disp_data <= pend_data;
            end
         end else if (load) begin
            pend      <= 1'b1;
            pend_data <= data_in;
         end
      end
   end

endmodule
